page_read_ctrl: RTL
===================

PAGE_READ_CTRL -- requirements
Module: page_read_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: n_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  in  1  request pulse from the FCU once the address phase is complete.
REQ-004 SHALL have: start_address  in  6  first word offset within the page.
REQ-005 SHALL have: block_address  in  10  page/block number.
REQ-006 SHALL have: rollover_value  in  6  word count, computed as end - start + 1 mod 64; 0 means 64.
REQ-007 SHALL have: mem_addr  out  16  memory read address, {block, offset}.
REQ-008 SHALL have: mem_read_en  out  1  one-cycle read strobe.
REQ-009 SHALL have: mem_rdata  in  8  read data; mem_rvalid  in  1  read data valid.
REQ-010 SHALL have: fifo_full  in  1  TX FIFO full; fifo_wdata  out  8; fifo_write  out  1  write strobe.
REQ-011 SHALL have: busy  out  1; done  out  1  one-cycle completion pulse; word_count  out  7  words pushed so far; error  out  1  read timeout flag.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, PUSH, FINISH.
REQ-013 IDLE: start=1 SHALL latch start_address, block_address and count, where count = rollover_value, or 64 when rollover_value=0; clear word_count and error; go to ISSUE.
REQ-014 ISSUE: if fifo_full=0, SHALL drive mem_read_en=1 with mem_addr={block, cur_offset} for one cycle and go to WAIT; if fifo_full=1, SHALL hold state with mem_read_en=0.
REQ-015 WAIT: on mem_rvalid=1, SHALL capture mem_rdata and go to PUSH; otherwise SHALL stay in WAIT.
REQ-016 PUSH: SHALL drive fifo_write=1 with the captured byte on fifo_wdata, increment cur_offset mod 64 (63 wraps to 0, block unchanged), increment word_count and decrement remaining; if remaining was 1, SHALL go to FINISH, else to ISSUE.
REQ-017 FINISH: SHALL drive done=1 for exactly one cycle, then go to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 start SHALL be ignored outside IDLE; mem_rvalid SHALL be ignored outside WAIT.
REQ-020 Minimum cost SHALL be 3 cycles per word (ISSUE, WAIT, PUSH), with done in the cycle after the last PUSH.
REQ-021 The module is the sole FIFO writer; a not-full check in ISSUE guarantees the slot for the following PUSH.
REQ-022 mem_read_en, fifo_write and done SHALL be 0 in every cycle where not stated above.

Reset
REQ-023 n_reset=0 SHALL immediately force IDLE and set mem_addr=0, mem_read_en=0, fifo_wdata=0, fifo_write=0, busy=0, done=0, word_count=0, error=0.
REQ-024 Reset mid-transfer SHALL abort with no done pulse; on release the module SHALL await a new start.

Configuration
REQ-025 Macro PRC_READ_TIMEOUT_EN SHALL control the read timeout.
- Defined: an 8-bit counter clears on WAIT entry and increments each WAIT cycle without mem_rvalid. At 255 the module SHALL set error=1, skip PUSH and go to FINISH (done pulses).
- error SHALL hold until the next accepted start or reset.
- Not defined: WAIT is unbounded, error is tied to 0, and no counter is synthesized.

Verification
REQ-026 Bench SHALL cover these scenarios (start at cycle 0; rvalid one cycle after read_en):
- start_address=5, block=3, rollover=3 -> mem_addr 0x00C5, 0x00C6, 0x00C7; three fifo_writes; done at cycle 10; word_count=3.
- start_address=62, block=1, rollover=4 -> offsets 62, 63, 0, 1; mem_addr 0x007E, 0x007F, 0x0040, 0x0041.
- start_address=0, rollover=0 -> exactly 64 fifo_writes, word_count=64, single done pulse.
- fifo_full=1 for 5 cycles while in ISSUE -> no mem_read_en in those cycles; transfer then resumes with no lost or duplicated bytes.
- n_reset asserted in WAIT of the 2nd word -> all outputs 0 at once, no done; a later start runs normally.
- PRC_READ_TIMEOUT_EN defined, mem_rvalid never asserted -> error=1 and done pulse 255 cycles after WAIT entry, fifo_write never 1.

Source files
------------

// File: rtl/page_read_ctrl.sv
// Page read controller: reads a run of words from one memory page into the TX FIFO.
// Optional read timeout is enabled by defining PRC_READ_TIMEOUT_EN.
`timescale 1ns/1ps
module page_read_ctrl (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [5:0]  start_address,
    input  logic [9:0]  block_address,
    input  logic [5:0]  rollover_value,
    output logic [15:0] mem_addr,
    output logic        mem_read_en,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    input  logic        fifo_full,
    output logic [7:0]  fifo_wdata,
    output logic        fifo_write,
    output logic        busy,
    output logic        done,
    output logic [6:0]  word_count,
    output logic        error,
    output logic [2:0]  state_dbg
);

    // Handshake: one mem_read_en strobe per word, then the first mem_rvalid seen
    // in WAIT is that word's data; fifo_write is only issued after a not-full ISSUE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_PUSH   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  offset_q, offset_d;
    logic [9:0]  block_q, block_d;
    logic [6:0]  remaining_q, remaining_d;
    logic [6:0]  word_count_q, word_count_d;
    logic [7:0]  data_q, data_d;
`ifdef PRC_READ_TIMEOUT_EN
    logic        error_q, error_d;
    logic [7:0]  tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= S_IDLE;
            offset_q     <= '0;
            block_q      <= '0;
            remaining_q  <= '0;
            word_count_q <= '0;
            data_q       <= '0;
`ifdef PRC_READ_TIMEOUT_EN
            error_q      <= 1'b0;
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            block_q      <= block_d;
            remaining_q  <= remaining_d;
            word_count_q <= word_count_d;
            data_q       <= data_d;
`ifdef PRC_READ_TIMEOUT_EN
            error_q      <= error_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        block_d      = block_q;
        remaining_d  = remaining_q;
        word_count_d = word_count_q;
        data_d       = data_q;
`ifdef PRC_READ_TIMEOUT_EN
        error_d      = error_q;
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    offset_d     = start_address;
                    block_d      = block_address;
                    remaining_d  = (rollover_value == 6'd0) ? 7'd64 : {1'b0, rollover_value};
                    word_count_d = '0;
`ifdef PRC_READ_TIMEOUT_EN
                    error_d      = 1'b0;
`endif
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!fifo_full) begin
`ifdef PRC_READ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    state_d = S_PUSH;
                end
`ifdef PRC_READ_TIMEOUT_EN
                // The 255th empty WAIT cycle is the one where the count reaches 255.
                else if (tmo_q == 8'd254) begin
                    error_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_PUSH: begin
                offset_d     = offset_q + 6'd1;
                word_count_d = word_count_q + 7'd1;
                remaining_d  = remaining_q - 7'd1;
                state_d      = (remaining_q == 7'd1) ? S_FINISH : S_ISSUE;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = {block_q, offset_q};
        mem_read_en = (state_q == S_ISSUE) && !fifo_full;
        fifo_wdata  = data_q;
        fifo_write  = (state_q == S_PUSH);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_FINISH);
        word_count  = word_count_q;
`ifdef PRC_READ_TIMEOUT_EN
        error       = error_q;
`else
        error       = 1'b0;
`endif
        state_dbg   = state_q;
    end

endmodule
